// File: rtl/bsg_wormhole_router_adapter_out.sv
// Wormhole link receiver: collects a header flit plus its body flits into one wide
// packet and presents it to the endpoint with a valid/ready handshake.
module bsg_wormhole_router_adapter_out #(
    parameter int flit_width_p        = 8,
    parameter int max_payload_width_p = 17,
    parameter int cord_width_p        = 4,
    parameter int len_width_p         = 2,
    localparam int max_packet_width_lp = max_payload_width_p + len_width_p + cord_width_p
) (
    input  logic                           clk_i,
    input  logic                           reset_i,

    input  logic [flit_width_p-1:0]        link_data_i,
    input  logic                           link_v_i,
    output logic                           link_ready_and_o,

    output logic [max_packet_width_lp-1:0] packet_o,
    output logic                           packet_v_o,
    input  logic                           packet_ready_and_i
);

    localparam int max_num_flit_lp = (max_packet_width_lp + flit_width_p - 1) / flit_width_p;

    typedef enum logic [1:0] {eHdr, eBody, eOut} state_e;

    state_e                         state_q, state_d;
    logic [len_width_p-1:0]         len_q, len_d;
    logic [len_width_p-1:0]         rem_q, rem_d;
    logic [max_packet_width_lp-1:0] pkt_q, pkt_d;

    logic                   flit_hs;
    logic                   pkt_hs;
    logic [len_width_p-1:0] hdr_len;
    logic [len_width_p-1:0] slice_idx;
    logic                   wr_en;
    int                     wr_slice;

    assign link_ready_and_o = ~reset_i & (state_q != eOut);
    assign packet_v_o       = (state_q == eOut);
    assign packet_o         = pkt_q;

    assign flit_hs   = link_v_i & link_ready_and_o;
    assign pkt_hs    = packet_v_o & packet_ready_and_i;
    assign hdr_len   = link_data_i[cord_width_p +: len_width_p];
    assign slice_idx = len_q - rem_q + len_width_p'(1);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        rem_d    = rem_q;
        pkt_d    = pkt_q;
        wr_en    = 1'b0;
        wr_slice = 0;

        case (state_q)
            eHdr: begin
                if (flit_hs) begin
                    pkt_d    = '0;
                    wr_en    = 1'b1;
                    wr_slice = 0;
                    len_d    = hdr_len;
                    rem_d    = hdr_len;
                    state_d  = (hdr_len == '0) ? eOut : eBody;
                end
            end
            eBody: begin
                if (flit_hs) begin
                    wr_en    = 1'b1;
                    wr_slice = int'(slice_idx);
                    rem_d    = rem_q - len_width_p'(1);
                    if (rem_q == len_width_p'(1)) begin
                        state_d = eOut;
                    end
                end
            end
            eOut: begin
                if (pkt_hs) begin
                    state_d = eHdr;
                end
            end
            default: state_d = eHdr;
        endcase

        // Bit-wise slice write; slices past the packet width simply match no bit.
        if (wr_en) begin
            for (int i = 0; i < max_packet_width_lp; i++) begin
                if (wr_slice == i / flit_width_p) begin
                    pkt_d[i] = link_data_i[i % flit_width_p];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= eHdr;
            len_q   <= '0;
            rem_q   <= '0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            pkt_q   <= pkt_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i && state_q == eHdr && flit_hs) begin
            assert (int'(hdr_len) <= max_num_flit_lp - 1)
                else $error("header len %0d exceeds max body flits", hdr_len);
        end
    end
`endif

endmodule

// File: tb/tb_bsg_wormhole_router_adapter_out.sv
// Directed bench for the wormhole packet reassembler at default parameters.
module tb_bsg_wormhole_router_adapter_out;

    logic        clk;
    logic        reset_i;
    logic [7:0]  link_data_i;
    logic        link_v_i;
    logic        link_ready_and_o;
    logic [22:0] packet_o;
    logic        packet_v_o;
    logic        packet_ready_and_i;

    int total;
    int bad;

    bsg_wormhole_router_adapter_out dut (
        .clk_i              (clk),
        .reset_i            (reset_i),
        .link_data_i        (link_data_i),
        .link_v_i           (link_v_i),
        .link_ready_and_o   (link_ready_and_o),
        .packet_o           (packet_o),
        .packet_v_o         (packet_v_o),
        .packet_ready_and_i (packet_ready_and_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1, "watchdog");
    end

    // Called on a negedge; returns on the negedge following the flit handshake.
    task automatic send_flit(input logic [7:0] d);
        int n;
        n = 0;
        link_data_i = d;
        link_v_i    = 1'b1;
        while (!link_ready_and_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("FAIL send_flit_timeout: ready=%b after %0d cycles, want 1", link_ready_and_o, n);
        end
        @(negedge clk);
        link_v_i    = 1'b0;
        link_data_i = 8'hEE;
    endtask

    task automatic accept_packet();
        packet_ready_and_i = 1'b1;
        @(negedge clk);
        packet_ready_and_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        link_v_i = 1'b0;
        link_data_i = 8'h00;
        packet_ready_and_i = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (link_ready_and_o !== 1'b0) begin
            bad++; $display("FAIL reset_ready: got %b want 0", link_ready_and_o);
        end
        total++;
        if (packet_v_o !== 1'b0) begin
            bad++; $display("FAIL reset_valid: got %b want 0", packet_v_o);
        end
        total++;
        if (packet_o !== 23'h0) begin
            bad++; $display("FAIL reset_packet: got %h want 000000", packet_o);
        end
        reset_i = 1'b0;
        @(negedge clk);
        total++;
        if (link_ready_and_o !== 1'b1) begin
            bad++; $display("FAIL post_reset_ready: got %b want 1", link_ready_and_o);
        end
    endtask

    task automatic test_three_flit();
        send_flit(8'h25);
        total++;
        if (link_ready_and_o !== 1'b1 || packet_v_o !== 1'b0) begin
            bad++; $display("FAIL three_flit_body_state: ready=%b v=%b want 1 0",
                            link_ready_and_o, packet_v_o);
        end
        send_flit(8'hAB);
        total++;
        if (packet_v_o !== 1'b0) begin
            bad++; $display("FAIL three_flit_early_valid: got %b want 0", packet_v_o);
        end
        send_flit(8'h7F);
        total++;
        if (packet_v_o !== 1'b1) begin
            bad++; $display("FAIL three_flit_valid: got %b want 1", packet_v_o);
        end
        total++;
        if (packet_o !== 23'h7FAB25) begin
            bad++; $display("FAIL three_flit_data: got %h want 7fab25", packet_o);
        end
        total++;
        if (link_ready_and_o !== 1'b0) begin
            bad++; $display("FAIL three_flit_held_ready: got %b want 0", link_ready_and_o);
        end
        accept_packet();
        total++;
        if (packet_v_o !== 1'b0 || link_ready_and_o !== 1'b1) begin
            bad++; $display("FAIL three_flit_release: v=%b ready=%b want 0 1",
                            packet_v_o, link_ready_and_o);
        end
    endtask

    task automatic test_two_flit();
        send_flit(8'h19);
        send_flit(8'hC4);
        total++;
        if (packet_v_o !== 1'b1 || packet_o !== 23'h00C419) begin
            bad++; $display("FAIL two_flit: v=%b data=%h want 1 00c419", packet_v_o, packet_o);
        end
        accept_packet();
    endtask

    task automatic test_single_flit();
        send_flit(8'h03);
        total++;
        if (packet_v_o !== 1'b1 || packet_o !== 23'h000003) begin
            bad++; $display("FAIL single_flit: v=%b data=%h want 1 000003", packet_v_o, packet_o);
        end
        accept_packet();
    endtask

    task automatic test_backpressure();
        send_flit(8'h25);
        send_flit(8'hAB);
        send_flit(8'h7F);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (packet_v_o !== 1'b1 || packet_o !== 23'h7FAB25 || link_ready_and_o !== 1'b0) begin
                bad++; $display("FAIL backpressure_hold[%0d]: v=%b data=%h ready=%b want 1 7fab25 0",
                                i, packet_v_o, packet_o, link_ready_and_o);
            end
            @(negedge clk);
        end
        // Offer the next header in the release cycle; it must wait one cycle.
        packet_ready_and_i = 1'b1;
        link_v_i = 1'b1;
        link_data_i = 8'h03;
        @(negedge clk);
        packet_ready_and_i = 1'b0;
        total++;
        if (link_ready_and_o !== 1'b1 || packet_v_o !== 1'b0) begin
            bad++; $display("FAIL backpressure_release: ready=%b v=%b want 1 0",
                            link_ready_and_o, packet_v_o);
        end
        @(negedge clk);
        link_v_i = 1'b0;
        total++;
        if (packet_v_o !== 1'b1 || packet_o !== 23'h000003) begin
            bad++; $display("FAIL backpressure_next_hdr: v=%b data=%h want 1 000003",
                            packet_v_o, packet_o);
        end
        accept_packet();
    endtask

    task automatic test_bubbles();
        logic [7:0] flits [3];
        int         gaps  [3];
        int         seen;
        flits = '{8'h25, 8'hAB, 8'h7F};
        gaps  = '{0, 2, 3};
        seen  = 0;
        for (int k = 0; k < 3; k++) begin
            for (int g = 0; g < gaps[k]; g++) begin
                total++;
                if (packet_v_o !== 1'b0) begin
                    bad++; $display("FAIL bubble_early_valid[%0d]: got %b want 0", k, packet_v_o);
                end
                @(negedge clk);
            end
            send_flit(flits[k]);
        end
        total++;
        if (packet_v_o !== 1'b1 || packet_o !== 23'h7FAB25) begin
            bad++; $display("FAIL bubble_packet: v=%b data=%h want 1 7fab25", packet_v_o, packet_o);
        end
        accept_packet();
        for (int i = 0; i < 4; i++) begin
            if (packet_v_o === 1'b1) seen++;
            @(negedge clk);
        end
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL bubble_extra_packet: got %0d valid cycles want 0", seen);
        end
    endtask

    task automatic test_mid_reset();
        send_flit(8'h25);
        send_flit(8'hAB);
        reset_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (packet_v_o !== 1'b0 || link_ready_and_o !== 1'b0) begin
                bad++; $display("FAIL mid_reset_during[%0d]: v=%b ready=%b want 0 0",
                                i, packet_v_o, link_ready_and_o);
            end
        end
        reset_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (packet_v_o !== 1'b0 || link_ready_and_o !== 1'b1) begin
                bad++; $display("FAIL mid_reset_after[%0d]: v=%b ready=%b want 0 1",
                                i, packet_v_o, link_ready_and_o);
            end
        end
        send_flit(8'h03);
        total++;
        if (packet_v_o !== 1'b1 || packet_o !== 23'h000003) begin
            bad++; $display("FAIL mid_reset_packet: v=%b data=%h want 1 000003",
                            packet_v_o, packet_o);
        end
        accept_packet();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_three_flit();
        test_two_flit();
        test_single_flit();
        test_backpressure();
        test_bubbles();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bsg_wormhole_router_adapter_out.md
Name: bsg_wormhole_router_adapter_out

Overview:
Receiving end of the wormhole link protocol. Accepts a stream of flits from a router output link and reassembles each header-plus-body flit sequence into one wide packet. Presents the packet with a valid/ready handshake to the endpoint. Used wherever a wormhole network terminates at a packet-level consumer.

Parameters:
flit_width_p, 8, link flit width in bits; must be >= cord_width_p+len_width_p
max_payload_width_p, 17, payload bits above the len field
cord_width_p, 4, destination coordinate width (packet LSBs)
len_width_p, 2, len field width; holds the count of body flits following the header
localparam max_packet_width_lp = max_payload_width_p+len_width_p+cord_width_p (23 at defaults)
localparam max_num_flit_lp = ceil(max_packet_width_lp/flit_width_p) (3 at defaults); len_width_p >= clog2(max_num_flit_lp)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
link_data_i  in  flit_width_p  incoming flit
link_v_i  in  1  flit valid
link_ready_and_o  out  1  block can accept a flit this cycle
packet_o  out  max_packet_width_lp  assembled packet {payload,len,cord}, cord at LSBs
packet_v_o  out  1  packet valid
packet_ready_and_i  in  1  consumer accepts the packet

Behaviour:
- Packet layout: flit k (k=0 is the header) occupies packet bits [k*flit_width_p +: flit_width_p]. Bits at or above max_packet_width_lp are dropped. Header len = link_data_i[cord_width_p +: len_width_p].
- Flit handshake = link_v_i & link_ready_and_o. Packet handshake = packet_v_o & packet_ready_and_i.
- FSM states:
  - eHdr: waiting for the header flit.
  - eBody: collecting body flits.
  - eOut: holding the assembled packet.
- Reset: state=eHdr, flit counter=0, packet register=0, packet_v_o=0, link_ready_and_o=0 while reset_i is high.
- link_ready_and_o = ~reset_i & (state != eOut). It is registered-state only, with no combinational path from packet_ready_and_i.
- packet_v_o = (state == eOut).
- eHdr, on a flit handshake:
  - Clear the whole packet register, then write the header into slice 0.
  - Load remaining = len.
  - If len==0, go to eOut; otherwise go to eBody.
- eBody, on a flit handshake:
  - Write the flit into slice (len-remaining+1) and decrement remaining.
  - When remaining reaches 0, go to eOut.
- eBody with no handshake: hold all state. There is no timeout.
- eOut: packet_o is stable while packet_v_o=1. On a packet handshake, go to eHdr. A new header is accepted no earlier than the following cycle.
- Slices above the last received flit read as 0 (e.g. a len=0 packet gives bits above flit_width_p equal to 0).
- Latency: packet_v_o rises the cycle after the final flit handshake. Peak throughput is one packet per (len+2) cycles.
- len > max_num_flit_lp-1 is illegal. A nonsynth assertion fires on it. RTL behaviour: the flit count follows len, and out-of-range slice writes are discarded.
- reset_i asserted mid-packet or in eOut: the partial or pending packet is discarded and the FSM returns to eHdr next cycle. No packet_v_o pulse is produced for discarded data.
- link_data_i is ignored whenever no flit handshake occurs. packet_ready_and_i is ignored outside eOut.

Test Plan:
- All tests use the default parameters.
- 3-flit packet: flits 0x25, 0xAB, 0x7F back-to-back.
  - packet_o=0x7FAB25, packet_v_o=1 exactly one cycle after the third flit.
  - link_ready_and_o=0 while held.
- Single-flit packet: flit 0x03 (len=0).
  - packet_o=0x000003 one cycle later.
- 2-flit packet: flits 0x19, 0xC4.
  - packet_o=0x00C419.
  - Upper slice is zero even though the previous packet wrote 0x7F there.
- Backpressure: packet_ready_and_i=0 for 5 cycles after 0x7FAB25 is assembled.
  - Output is stable and link_ready_and_o=0 throughout.
  - On release, link_ready_and_o=1 the next cycle and the next header is accepted.
- Bubbles: link_v_i randomly deasserted between flits of 0x25, 0xAB, 0x7F.
  - Same 0x7FAB25 output, no extra or missing packets.
- Mid-packet reset: reset_i after flits 0x25, 0xAB, then send 0x03.
  - Only 0x000003 is delivered, and packet_v_o stays 0 during and after reset until then.
